// File: rtl/gpio_fault_loopback_if.sv
// Bus bundle between the GPIO loopback fault model and its bench driver.
// Stuck-at ports exist only when LOOPBACK_STUCK_EN is defined.
interface gpio_fault_loopback_if #(
    parameter int DATA_W = 16,
    parameter int CNT_W  = 8
);
    logic [DATA_W:0]   GPIOOUT_i;
    logic [DATA_W:0]   GPIOIN_o;
    logic [1:0]        err_mode_i;
    logic              err_trig_i;
    logic [CNT_W-1:0]  err_len_i;
    logic [DATA_W:0]   err_mask_i;
    logic              cnt_clr_i;
    logic              inj_active_o;
    logic [CNT_W-1:0]  inj_cnt_o;
`ifdef LOOPBACK_STUCK_EN
    logic [DATA_W:0]   stuck_mask_i;
    logic [DATA_W:0]   stuck_val_i;
`endif

    modport master (
        output GPIOOUT_i, err_mode_i, err_trig_i, err_len_i, err_mask_i, cnt_clr_i,
`ifdef LOOPBACK_STUCK_EN
        output stuck_mask_i, stuck_val_i,
`endif
        input  GPIOIN_o, inj_active_o, inj_cnt_o
    );

    modport slave (
        input  GPIOOUT_i, err_mode_i, err_trig_i, err_len_i, err_mask_i, cnt_clr_i,
`ifdef LOOPBACK_STUCK_EN
        input  stuck_mask_i, stuck_val_i,
`endif
        output GPIOIN_o, inj_active_o, inj_cnt_o
    );
endinterface

// File: rtl/gpio_fault_loopback.sv
// GPIO loopback delay line with mode-driven bit-flip injection and a saturating
// corrupted-cycle counter. Optional stuck-at overlay: LOOPBACK_STUCK_EN.
module gpio_fault_loopback #(
    parameter int DATA_W = 16,
    parameter int DELAY  = 1,
    parameter int CNT_W  = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    gpio_fault_loopback_if.slave  bus
);
    localparam int BW = DATA_W + 1;
    localparam logic [1:0] MODE_OFF     = 2'b00;
    localparam logic [1:0] MODE_CONT    = 2'b01;
    localparam logic [1:0] MODE_ONESHOT = 2'b10;
    localparam logic [1:0] MODE_BURST   = 2'b11;
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    typedef enum logic {ST_IDLE = 1'b0, ST_INJECT = 1'b1} state_e;

    state_e            state_q, state_d;
    logic [1:0]        mode_q, mode_d;
    logic [CNT_W-1:0]  rem_q, rem_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [BW-1:0]     mask_q, mask_d;
    logic              trig_q;
    logic [BW-1:0]     stage_q [DELAY];
    logic              trig_rise_s;
    logic              inj_s;
    logic [BW-1:0]     flip_s;

    assign trig_rise_s = bus.err_trig_i & ~trig_q;
    assign inj_s       = (state_q == ST_INJECT);

    // Delay line, trigger history and injection registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DELAY; i++) begin
                stage_q[i] <= {BW{1'b0}};
            end
            trig_q  <= 1'b0;
            state_q <= ST_IDLE;
            mode_q  <= MODE_OFF;
            rem_q   <= CNT_ZERO;
            mask_q  <= {BW{1'b0}};
            cnt_q   <= CNT_ZERO;
        end else begin
            stage_q[0] <= bus.GPIOOUT_i;
            for (int i = 1; i < DELAY; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
            trig_q  <= bus.err_trig_i;
            state_q <= state_d;
            mode_q  <= mode_d;
            rem_q   <= rem_d;
            mask_q  <= mask_d;
            cnt_q   <= cnt_d;
        end
    end

    // Injection FSM: mode_q remembers which mode opened the window so any change closes it
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        rem_d   = rem_q;
        mask_d  = mask_q;
        case (state_q)
            ST_IDLE: begin
                case (bus.err_mode_i)
                    MODE_CONT: begin
                        state_d = ST_INJECT;
                        mode_d  = MODE_CONT;
                        rem_d   = CNT_ZERO;
                        mask_d  = bus.err_mask_i;
                    end
                    MODE_ONESHOT: begin
                        if (trig_rise_s) begin
                            state_d = ST_INJECT;
                            mode_d  = MODE_ONESHOT;
                            rem_d   = CNT_ONE;
                            mask_d  = bus.err_mask_i;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                    MODE_BURST: begin
                        if (trig_rise_s && (bus.err_len_i != CNT_ZERO)) begin
                            state_d = ST_INJECT;
                            mode_d  = MODE_BURST;
                            rem_d   = bus.err_len_i;
                            mask_d  = bus.err_mask_i;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                    default: state_d = ST_IDLE;
                endcase
            end
            ST_INJECT: begin
                if (bus.err_mode_i != mode_q) begin
                    state_d = ST_IDLE;
                end else if (mode_q == MODE_CONT) begin
                    mask_d = bus.err_mask_i;
                end else if (rem_q == CNT_ONE) begin
                    state_d = ST_IDLE;
                    rem_d   = CNT_ZERO;
                end else begin
                    rem_d = rem_q - CNT_ONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Corrupted-cycle counter; clear wins over increment
    always_comb begin
        cnt_d = cnt_q;
        if (bus.cnt_clr_i) begin
            cnt_d = CNT_ZERO;
        end else if (inj_s && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_ONE;
        end else begin
            cnt_d = cnt_q;
        end
    end

    assign flip_s = stage_q[DELAY-1] ^ (inj_s ? mask_q : {BW{1'b0}});

`ifdef LOOPBACK_STUCK_EN
    assign bus.GPIOIN_o = (flip_s & ~bus.stuck_mask_i) | (bus.stuck_val_i & bus.stuck_mask_i);
`else
    assign bus.GPIOIN_o = flip_s;
`endif
    assign bus.inj_active_o = inj_s;
    assign bus.inj_cnt_o    = cnt_q;
endmodule

// File: tb/tb_gpio_fault_loopback.sv
// Randomised + directed bench for gpio_fault_loopback against a window-based reference model.
module tb_gpio_fault_loopback;
    localparam int DATA_W = 16;
    localparam int DELAY  = 3;
    localparam int CNT_W  = 8;
    localparam int BW     = DATA_W + 1;

    logic clk;
    logic reset_n;
    int   n_cmp = 0;
    int   n_err = 0;

    gpio_fault_loopback_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

    gpio_fault_loopback #(.DATA_W(DATA_W), .DELAY(DELAY), .CNT_W(CNT_W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: a corruption "window" with a kind and remaining length (0 = unbounded)
    logic [BW-1:0] hist [DELAY];
    bit            m_on;
    logic [1:0]    m_kind;
    int            m_left;
    logic [BW-1:0] m_mask;
    int            m_cnt;
    bit            m_prev_trig;

    initial begin
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) begin
                for (int i = 0; i < DELAY; i++) hist[i] = '0;
                m_on = 0; m_kind = 2'b00; m_left = 0; m_mask = '0; m_cnt = 0; m_prev_trig = 0;
            end else begin
                bit rise;
                rise = bus.err_trig_i && !m_prev_trig;
                if (bus.cnt_clr_i) m_cnt = 0;
                else if (m_on) m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
                if (m_on) begin
                    if (bus.err_mode_i != m_kind) m_on = 0;
                    else if (m_left == 0) m_mask = bus.err_mask_i;
                    else begin
                        m_left = m_left - 1;
                        if (m_left == 0) m_on = 0;
                    end
                end else begin
                    m_kind = bus.err_mode_i;
                    m_mask = bus.err_mask_i;
                    if (bus.err_mode_i == 2'b01) begin m_on = 1; m_left = 0; end
                    else if (bus.err_mode_i == 2'b10 && rise) begin m_on = 1; m_left = 1; end
                    else if (bus.err_mode_i == 2'b11 && rise && bus.err_len_i != 0) begin
                        m_on = 1; m_left = int'(bus.err_len_i);
                    end
                end
                for (int i = DELAY - 1; i > 0; i--) hist[i] = hist[i-1];
                hist[0] = bus.GPIOOUT_i;
                m_prev_trig = bus.err_trig_i;
            end
        end
    end

    function automatic logic [BW-1:0] model_in();
        logic [BW-1:0] v;
        v = hist[DELAY-1] ^ (m_on ? m_mask : '0);
`ifdef LOOPBACK_STUCK_EN
        v = (v & ~bus.stuck_mask_i) | (bus.stuck_val_i & bus.stuck_mask_i);
`endif
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare away from the active edge
    initial begin
        forever begin
            @(negedge clk);
            chk("model_gpioin", 32'(bus.GPIOIN_o), 32'(model_in()));
            chk("model_active", 32'(bus.inj_active_o), 32'(m_on));
            chk("model_cnt", 32'(bus.inj_cnt_o), 32'(m_cnt));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int nact;

    initial begin
        reset_n = 1'b0;
        bus.GPIOOUT_i = '0; bus.err_mode_i = 2'b00; bus.err_trig_i = 1'b0;
        bus.err_len_i = '0; bus.err_mask_i = '0; bus.cnt_clr_i = 1'b0;
`ifdef LOOPBACK_STUCK_EN
        bus.stuck_mask_i = '0; bus.stuck_val_i = '0;
`endif
        tick(); tick(); tick();
        chk("reset_gpioin", 32'(bus.GPIOIN_o), 32'h0);
        chk("reset_active", 32'(bus.inj_active_o), 32'h0);
        chk("reset_cnt", 32'(bus.inj_cnt_o), 32'h0);
        reset_n = 1'b1;
        tick(); tick();

        // Pure delay, mode OFF
        bus.GPIOOUT_i = 17'h1A5A5;
        tick();
        bus.GPIOOUT_i = 17'h00000;
        tick();
        chk("delay_e1", 32'(bus.GPIOIN_o), 32'h0);
        tick();
        chk("delay_e2", 32'(bus.GPIOIN_o), 32'h1A5A5);
        tick();
        chk("delay_e3", 32'(bus.GPIOIN_o), 32'h0);
        chk("delay_cnt", 32'(bus.inj_cnt_o), 32'h0);

        // One-shot
        bus.GPIOOUT_i = 17'h00F0F;
        tick(); tick(); tick(); tick();
        bus.err_mask_i = 17'h10000; bus.err_mode_i = 2'b10; bus.err_trig_i = 1'b1;
        tick();
        chk("oneshot_data", 32'(bus.GPIOIN_o), 32'h10F0F);
        chk("oneshot_active", 32'(bus.inj_active_o), 32'h1);
        bus.err_trig_i = 1'b0;
        tick();
        chk("oneshot_after", 32'(bus.GPIOIN_o), 32'h00F0F);
        chk("oneshot_cnt", 32'(bus.inj_cnt_o), 32'h1);
        bus.err_trig_i = 1'b1;
        nact = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (bus.inj_active_o) nact++;
        end
        bus.err_trig_i = 1'b0;
        tick();
        chk("oneshot_held", nact, 1);
        chk("oneshot_cnt2", 32'(bus.inj_cnt_o), 32'h2);

        // Burst
        bus.cnt_clr_i = 1'b1;
        tick();
        chk("clr_cnt", 32'(bus.inj_cnt_o), 32'h0);
        bus.cnt_clr_i = 1'b0;
        bus.err_mode_i = 2'b11; bus.err_len_i = 8'd4; bus.err_mask_i = 17'h00001;
        bus.err_trig_i = 1'b1;
        nact = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            bus.err_trig_i = 1'b0;
            if (bus.inj_active_o && bus.GPIOIN_o == 17'h00F0E) nact++;
        end
        chk("burst_len", nact, 4);
        chk("burst_cnt", 32'(bus.inj_cnt_o), 32'h4);
        bus.err_trig_i = 1'b1;
        nact = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            bus.err_trig_i = (i == 1);
            if (bus.inj_active_o && bus.GPIOIN_o == 17'h00F0E) nact++;
        end
        bus.err_trig_i = 1'b0;
        chk("burst_retrig", nact, 4);
        chk("burst_cnt2", 32'(bus.inj_cnt_o), 32'h8);
        tick();
        bus.err_len_i = 8'd0; bus.err_trig_i = 1'b1;
        nact = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            bus.err_trig_i = 1'b0;
            if (bus.inj_active_o) nact++;
        end
        chk("burst_len0", nact, 0);

        // Continuous with saturation
        bus.err_mode_i = 2'b01; bus.err_mask_i = 17'h0FFFF;
        for (int i = 0; i < 300; i++) tick();
        chk("cont_sat", 32'(bus.inj_cnt_o), 32'd255);
        chk("cont_active", 32'(bus.inj_active_o), 32'h1);
        bus.cnt_clr_i = 1'b1;
        tick();
        chk("cont_clr", 32'(bus.inj_cnt_o), 32'h0);
        bus.cnt_clr_i = 1'b0;
        bus.err_mode_i = 2'b00;
        tick(); tick();
        chk("cont_off", 32'(bus.inj_active_o), 32'h0);

        // Reset in the middle of a burst
        bus.err_mode_i = 2'b11; bus.err_len_i = 8'd10; bus.err_mask_i = 17'h1FFFF;
        bus.err_trig_i = 1'b1;
        tick();
        bus.err_trig_i = 1'b0;
        tick(); tick();
        #2 reset_n = 1'b0;
        #1;
        chk("rst_mid_gpioin", 32'(bus.GPIOIN_o), 32'h0);
        chk("rst_mid_active", 32'(bus.inj_active_o), 32'h0);
        @(posedge clk);
        #2;
        reset_n = 1'b1;
        bus.err_mode_i = 2'b00;
        bus.GPIOOUT_i = 17'h0ABCD;
        tick(); tick(); tick();
        chk("rst_clean", 32'(bus.GPIOIN_o), 32'h0ABCD);
        chk("rst_clean_act", 32'(bus.inj_active_o), 32'h0);

`ifdef LOOPBACK_STUCK_EN
        bus.GPIOOUT_i = 17'h0FFFF;
        bus.stuck_mask_i = 17'h00003; bus.stuck_val_i = 17'h00001;
        tick(); tick(); tick();
        chk("stuck_data", 32'(bus.GPIOIN_o), 32'h0FFFD);
        chk("stuck_cnt", 32'(bus.inj_cnt_o), 32'h0);
        bus.stuck_mask_i = '0; bus.stuck_val_i = '0;
`endif

        // Randomised phase
        for (int i = 0; i < 3000; i++) begin
            bus.GPIOOUT_i = BW'($urandom);
            if ($urandom_range(0, 39) == 0) bus.err_mode_i = 2'($urandom_range(0, 3));
            bus.err_trig_i = ($urandom_range(0, 3) == 0);
            bus.err_len_i = CNT_W'($urandom_range(0, 6));
            bus.err_mask_i = ($urandom_range(0, 7) == 0) ? '0 : BW'($urandom);
            bus.cnt_clr_i = ($urandom_range(0, 63) == 0);
`ifdef LOOPBACK_STUCK_EN
            bus.stuck_mask_i = ($urandom_range(0, 3) == 0) ? BW'($urandom) : '0;
            bus.stuck_val_i = BW'($urandom);
`endif
            tick();
        end

        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/gpio_fault_loopback.md
Name: gpio_fault_loopback

Overview:
Parametrised GPIO loopback model for AHB GPIO unit benches. It drives the DUT's output bus back to its input bus through a configurable-depth register delay line. It injects bit-flip faults under a mode-driven state machine: off, continuous, one-shot or counted burst. A saturating counter reports how many cycles were corrupted, for scoreboard cross-checks.

Parameters:
DATA_W, 16, data bits; bus width is DATA_W+1, with the MSB as the parity bit
DELAY, 1, loopback latency in clk cycles, legal range 1..8
CNT_W, 8, width of the injected-cycle counter

Ports:
clk  input  1  clock
reset_n  input  1  asynchronous active-low reset
GPIOOUT_i  input  DATA_W+1  DUT output bus
GPIOIN_o  output  DATA_W+1  looped-back bus to DUT input
err_mode_i  input  2  00 OFF, 01 CONT, 10 ONESHOT, 11 BURST
err_trig_i  input  1  injection trigger, rising-edge sensitive
err_len_i  input  CNT_W  burst length in cycles (BURST mode only)
err_mask_i  input  DATA_W+1  bits to flip while injecting
cnt_clr_i  input  1  synchronous clear of inj_cnt_o
inj_active_o  output  1  high in every cycle in which GPIOIN_o is corrupted
inj_cnt_o  output  CNT_W  saturating count of corrupted cycles

Behaviour:
- Interface: one clock, clk. Reset reset_n is asynchronous, active-low. All state is cleared on assertion.
- Reset values: delay stages 0, GPIOIN_o 0, inj_active_o 0, inj_cnt_o 0, FSM IDLE, trig_q 0.
- Delay line:
  - stage[0] <= GPIOOUT_i; stage[i] <= stage[i-1].
  - GPIOIN_o = stage[DELAY-1] ^ (inj_q ? mask_q : 0), combinational from registers.
  - A value on GPIOOUT_i at edge k appears on GPIOIN_o after edge k+DELAY-1 (DELAY=1 means one-cycle latency).
- Trigger edge: trig_rise = err_trig_i & ~trig_q. trig_q is registered every cycle.
- FSM states IDLE and INJECT; inj_q = (state==INJECT). inj_active_o = inj_q.
- From IDLE:
  - CONT: go to INJECT whenever mode==CONT; no trigger needed.
  - ONESHOT: on trig_rise, go to INJECT with remaining=1.
  - BURST: on trig_rise with err_len_i != 0, go to INJECT with remaining=err_len_i. err_len_i==0 means the trigger is ignored.
  - mask_q <= err_mask_i is latched on the same edge as the transition.
- In INJECT:
  - CONT: stay while mode==CONT. mask_q tracks err_mask_i each cycle.
  - ONESHOT/BURST: decrement remaining each cycle; return to IDLE on the edge where remaining==1. Corruption lasts exactly 1 or err_len_i cycles.
  - A mode change to OFF, or to any mode other than the one that entered INJECT, returns to IDLE on the next edge. No further corruption cycles occur.
  - trig_rise while in INJECT is ignored, with no retrigger or extension.
- Faults are applied at the output. Data already in the delay line is corrupted only during inj_q cycles; stage contents are never modified.
- Counter:
  - inj_cnt_o increments each cycle inj_q==1 and saturates at 2^CNT_W-1.
  - cnt_clr_i has priority over increment; on a simultaneous clear and increment the result is 0.
- Mid-operation reset: an asynchronous reset during a burst aborts it immediately. GPIOIN_o goes to 0 with no residual corruption after release.
- err_mask_i==0 while injecting: inj_active_o and the counter still run; the data is uncorrupted.

Optional Feature:
LOOPBACK_STUCK_EN
- With the macro defined:
  - Adds ports stuck_mask_i input DATA_W+1 and stuck_val_i input DATA_W+1.
  - After the flip, GPIOIN_o = (flipped & ~stuck_mask_i) | (stuck_val_i & stuck_mask_i). This models stuck-at pins.
  - Stuck bits do not affect inj_active_o or inj_cnt_o.
- Without the macro: the ports are absent and GPIOIN_o is the flipped value only.

Test Plan:
- DELAY=3, mode OFF, GPIOOUT_i=0x1A5A5 at edge 0 -> GPIOIN_o=0x1A5A5 after edge 2, unchanged otherwise; inj_cnt_o=0.
- ONESHOT, mask=0x10000, data 0x00F0F held, trig pulse -> exactly one cycle GPIOIN_o=0x10F0F, inj_active_o pulse of one cycle, inj_cnt_o=1; trigger held high for 5 cycles still yields one injection.
- BURST, err_len_i=4, mask=0x00001 -> bit0 inverted for 4 consecutive cycles, inj_cnt_o=4; retrigger during burst -> still 4; err_len_i=0 trigger -> no injection.
- CONT for 300 cycles with CNT_W=8 -> inj_cnt_o saturates at 255; cnt_clr_i asserted with inj_q high -> inj_cnt_o=0 next cycle.
- BURST len=10, reset_n low at burst cycle 3 -> GPIOIN_o=0, inj_active_o=0 immediately; after release, data passes clean.
- LOOPBACK_STUCK_EN defined, stuck_mask=0x00003, stuck_val=0x00001, data 0x0FFFF -> GPIOIN_o=0x0FFFD; inj_cnt_o unchanged.
